mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Sequencing control FSM directly upstream of MIPS_datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control inputs, including PC_en.
- Provides ready handshakes to the instruction and data memories.
- Produces ALUOp for the ALU controller and retire/error status for debug.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for dmem_ready before abort (0 = no timeout)
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset on next rising clk)
OpCode  input  6  instr[31:26] from datapath
funct  input  6  instr[5:0] from datapath
imem_ready  input  1  instruction memory word valid this cycle
dmem_ready  input  1  data memory access complete this cycle
RegDst  output  1  write reg = rd
Jump  output  1  select jump target
Branch  output  1  branch-if-zero enable
MemRead  output  1  data memory read strobe
MemToReg  output  1  writeback from memory
MemWrite  output  1  data memory write strobe
ALUSrc  output  1  ALU B = sign-extended immediate
RegWrite  output  1  register file write strobe
Link  output  1  jal: write PC+4 to $31
JR  output  1  next PC = rs
PC_en  output  1  PC update strobe
ALUOp  output  2  00 add, 01 sub, 10 use funct
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
illegal_instr  output  1  one-cycle pulse in WB of an undecoded opcode
mem_error  output  1  one-cycle pulse in WB of a timed-out memory access
instr_count  output  CNT_WIDTH  instructions retired

Behaviour:
Reset:
- reset=0 at a rising edge forces state=FETCH, instr_count=0 and the wait counter to 0.
- All other outputs are 0.
- Applies from any state, including mid-MEM. No write or PC update occurs in the reset cycle.

State transitions:
- FETCH: wait for imem_ready=1, then latch OpCode/funct into op_q/funct_q and go to DECODE. Hold FETCH while imem_ready=0.
- DECODE (1 cycle): if op_q is illegal, go to WB. Otherwise go to EXEC.
- EXEC (1 cycle): lw/sw go to MEM; all other instructions go to WB.
- MEM: MemRead=1 (lw) or MemWrite=1 (sw) on every cycle in MEM.
  - Stay while dmem_ready=0.
  - dmem_ready=1: go to WB.
  - If MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT-1 with dmem_ready still 0: go to WB with the abort flag set.
- WB (1 cycle): PC_en=1. RegWrite=1 per the decode below, suppressed if illegal or aborted. Then go to FETCH.

Output timing:
- Static decode outputs (RegDst, ALUSrc, MemToReg, Branch, Jump, Link, JR, ALUOp) come from op_q/funct_q in DECODE..WB. They are 0 in FETCH.
- Strobes: MemRead/MemWrite are active only in MEM; RegWrite/PC_en only in WB.
- Nothing may write state outside those states.

Decode (op_q):
- 000000 R-type: RegDst, ALUOp=10, RegWrite. If funct_q=001000 (jr): JR=1, RegWrite=0.
- 100011 lw: ALUSrc, MemToReg, ALUOp=00, RegWrite.
- 101011 sw: ALUSrc, ALUOp=00.
- 000100 beq: Branch, ALUOp=01.
- 001000 addi: ALUSrc, ALUOp=00, RegWrite.
- 000010 j: Jump.
- 000011 jal: Jump, Link, RegWrite.
- Any other opcode is illegal: all decode outputs 0, PC_en=1 (executes as NOP), illegal_instr pulses in WB.

Latency (imem_ready/dmem_ready tied 1):
- R/addi/beq/j/jal/jr: 4 cycles.
- lw/sw: 5 cycles.
- Illegal: 3 cycles.
- Each ready=0 cycle adds one.

Status and counters:
- instr_count increments by 1 in every WB, including illegal and aborted instructions. Wraps from all-ones to 0.
- mem_error pulses in WB when the abort flag is set. On abort, RegWrite=0; PC_en is still 1.
- The wait counter clears on entering MEM.
- dmem_ready outside MEM and imem_ready outside FETCH are ignored.

Test Plan:
- Reset held 0 for 2 cycles mid-MEM of an lw, then released → state=0, all strobes 0, instr_count=0; next FETCH proceeds normally.
- add (op 000000, funct 100000), readies=1 → states 0,1,2,4; in WB RegWrite=1, RegDst=1, ALUOp=10, PC_en=1; instr_count=1.
- lw (100011) with dmem_ready low for 3 MEM cycles → MEM lasts 4 cycles with MemRead=1 throughout; WB has MemToReg=1, RegWrite=1; total 8 cycles.
- sw with dmem_ready stuck 0, MEM_TIMEOUT=16 → exactly 16 MEM cycles with MemWrite=1; WB has mem_error=1, RegWrite=0, PC_en=1.
- jal (000011) then jr (000000/001000) → jal WB: Jump=1, Link=1, RegWrite=1; jr WB: JR=1, RegWrite=0, PC_en=1.
- Opcode 111111 → states 0,1,4; WB has illegal_instr=1, PC_en=1, RegWrite=0. With instr_count preloaded to all-ones via 2^32-1 retires (or a CNT_WIDTH=4 build after 15 retires), one more retire wraps it to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath/memory-facing signal bundle of the multicycle MIPS controller.
// The controller side uses the master modport; the datapath/memory side uses slave.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           OpCode;
    logic [5:0]           funct;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 RegDst;
    logic                 Jump;
    logic                 Branch;
    logic                 MemRead;
    logic                 MemToReg;
    logic                 MemWrite;
    logic                 ALUSrc;
    logic                 RegWrite;
    logic                 Link;
    logic                 JR;
    logic                 PC_en;
    logic [1:0]           ALUOp;
    logic [2:0]           state;
    logic                 illegal_instr;
    logic                 mem_error;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  OpCode, funct, imem_ready, dmem_ready,
        output RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc,
               RegWrite, Link, JR, PC_en, ALUOp, state, illegal_instr,
               mem_error, instr_count
    );

    modport slave (
        output OpCode, funct, imem_ready, dmem_ready,
        input  RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc,
               RegWrite, Link, JR, PC_en, ALUOp, state, illegal_instr,
               mem_error, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath control strobes.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam int         WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       link;
        logic       jr;
        logic [1:0] alu_op;
        logic       legal;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                d.reg_dst = 1'b1;
                d.alu_op  = 2'b10;
                if (fn == FN_JR) d.jr = 1'b1;
                else             d.reg_write = 1'b1;
            end
            OP_LW:   begin d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; end
            OP_SW:   begin d.alu_src = 1'b1; d.mem_write = 1'b1; end
            OP_BEQ:  begin d.branch = 1'b1; d.alu_op = 2'b01; end
            OP_ADDI: begin d.alu_src = 1'b1; d.reg_write = 1'b1; end
            OP_J:    d.jump = 1'b1;
            OP_JAL:  begin d.jump = 1'b1; d.link = 1'b1; d.reg_write = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t               st, nxt_state;
    logic [5:0]           op_q, funct_q, nxt_op, nxt_fn;
    logic                 abort_q, nxt_abort;
    logic [WAIT_W-1:0]    wait_q, nxt_wait;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 is_mem, busy, in_mem, in_wb;
    dec_t                 nd;

    assign is_mem          = (op_q == OP_LW) || (op_q == OP_SW);
    assign bus.state       = st;
    assign bus.instr_count = cnt_q;

    always_comb begin
        nxt_state = st;
        nxt_op    = op_q;
        nxt_fn    = funct_q;
        nxt_abort = abort_q;
        nxt_wait  = wait_q;
        case (st)
            FETCH: if (bus.imem_ready) begin
                nxt_state = DECODE;
                nxt_op    = bus.OpCode;
                nxt_fn    = bus.funct;
                nxt_abort = 1'b0;
            end
            DECODE: nxt_state = decode(op_q, funct_q).legal ? EXEC : WB;
            EXEC: begin
                nxt_state = is_mem ? MEM : WB;
                nxt_wait  = '0;
            end
            MEM: begin
                if (bus.dmem_ready) begin
                    nxt_state = WB;
                end else if (MEM_TIMEOUT > 0 && wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    nxt_state = WB;
                    nxt_abort = 1'b1;
                end else begin
                    nxt_wait = wait_q + 1'b1;
                end
            end
            default: nxt_state = FETCH;
        endcase
        // Outputs are registered, so they are decoded for the state being entered.
        nd     = decode(nxt_op, nxt_fn);
        busy   = (nxt_state != FETCH);
        in_mem = (nxt_state == MEM);
        in_wb  = (nxt_state == WB);
    end

    always_ff @(posedge clk) begin
        op_q    <= nxt_op;
        funct_q <= nxt_fn;
        if (!reset) begin
            st                <= FETCH;
            cnt_q             <= '0;
            wait_q            <= '0;
            abort_q           <= 1'b0;
            bus.RegDst        <= 1'b0;
            bus.Jump          <= 1'b0;
            bus.Branch        <= 1'b0;
            bus.MemRead       <= 1'b0;
            bus.MemToReg      <= 1'b0;
            bus.MemWrite      <= 1'b0;
            bus.ALUSrc        <= 1'b0;
            bus.RegWrite      <= 1'b0;
            bus.Link          <= 1'b0;
            bus.JR            <= 1'b0;
            bus.PC_en         <= 1'b0;
            bus.ALUOp         <= 2'b00;
            bus.illegal_instr <= 1'b0;
            bus.mem_error     <= 1'b0;
        end else begin
            st      <= nxt_state;
            wait_q  <= nxt_wait;
            abort_q <= nxt_abort;
            if (in_wb) cnt_q <= cnt_q + 1'b1;
            bus.RegDst        <= busy && nd.reg_dst;
            bus.Jump          <= busy && nd.jump;
            bus.Branch        <= busy && nd.branch;
            bus.MemToReg      <= busy && nd.mem_to_reg;
            bus.ALUSrc        <= busy && nd.alu_src;
            bus.Link          <= busy && nd.link;
            bus.JR            <= busy && nd.jr;
            bus.ALUOp         <= busy ? nd.alu_op : 2'b00;
            bus.MemRead       <= in_mem && nd.mem_read;
            bus.MemWrite      <= in_mem && nd.mem_write;
            // An aborted memory access must not commit a register write.
            bus.RegWrite      <= in_wb && nd.reg_write && !nxt_abort;
            bus.PC_en         <= in_wb;
            bus.illegal_instr <= in_wb && !nd.legal;
            bus.mem_error     <= in_wb && nxt_abort;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instructions push their
// expected WB record; a negedge monitor pops and compares at every PC_en.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_WIDTH(4)) bus ();
    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Control vector order: RegDst Jump Branch MemToReg ALUSrc RegWrite Link JR ALUOp[1:0] illegal
    localparam logic [10:0] C_ADD  = 11'b1_0_0_0_0_1_0_0_10_0;
    localparam logic [10:0] C_LW   = 11'b0_0_0_1_1_1_0_0_00_0;
    localparam logic [10:0] C_SW   = 11'b0_0_0_0_1_0_0_0_00_0;
    localparam logic [10:0] C_BEQ  = 11'b0_0_1_0_0_0_0_0_01_0;
    localparam logic [10:0] C_ADDI = 11'b0_0_0_0_1_1_0_0_00_0;
    localparam logic [10:0] C_J    = 11'b0_1_0_0_0_0_0_0_00_0;
    localparam logic [10:0] C_JAL  = 11'b0_1_0_0_0_1_1_0_00_0;
    localparam logic [10:0] C_JR   = 11'b1_0_0_0_0_0_0_1_10_0;
    localparam logic [10:0] C_ILL  = 11'b0_0_0_0_0_0_0_0_00_1;

    typedef struct {
        string       name;
        logic [10:0] ctl;
        logic        merr;
        logic [3:0]  cnt;
        int          lat;
        int          memc;
        int          rdc;
        int          wrc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt;
    int         cyc = 0, memc = 0, rdc = 0, wrc = 0;
    logic       inv_bad;

    function automatic logic [10:0] ctl_now();
        return {bus.RegDst, bus.Jump, bus.Branch, bus.MemToReg, bus.ALUSrc, bus.RegWrite,
                bus.Link, bus.JR, bus.ALUOp, bus.illegal_instr};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, before the driver updates inputs.
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0; memc = 0; rdc = 0; wrc = 0;
        end else begin
            cyc++;
            if (bus.state == 3'd3) memc++;
            if (bus.MemRead)       rdc++;
            if (bus.MemWrite)      wrc++;
            inv_bad = (bus.state > 3'd4) ||
                      (bus.state == 3'd0 && (ctl_now() != '0 || bus.MemRead || bus.MemWrite ||
                                             bus.PC_en || bus.mem_error)) ||
                      ((bus.RegWrite || bus.PC_en || bus.illegal_instr || bus.mem_error) && bus.state != 3'd4) ||
                      ((bus.MemRead || bus.MemWrite) && bus.state != 3'd3);
            check("invariant", int'(inv_bad), 0);
            if (bus.PC_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_wb", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_ctl"},      int'(ctl_now()),         int'(mon_e.ctl));
                    check({mon_e.name, "_memerr"},   int'(bus.mem_error),     int'(mon_e.merr));
                    check({mon_e.name, "_count"},    int'(bus.instr_count),   int'(mon_e.cnt));
                    check({mon_e.name, "_latency"},  cyc,                     mon_e.lat);
                    check({mon_e.name, "_memcyc"},   memc,                    mon_e.memc);
                    check({mon_e.name, "_readcyc"},  rdc,                     mon_e.rdc);
                    check({mon_e.name, "_writecyc"}, wrc,                     mon_e.wrc);
                end
                cyc = 0; memc = 0; rdc = 0; wrc = 0;
            end
        end
    end

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int iw, input int dw, input logic [10:0] ctl, input logic merr,
                             input int lat, input int memc_e, input int rdc_e, input int wrc_e);
        exp_t e;
        int   n;
        exp_cnt = exp_cnt + 4'd1;
        e.name = name; e.ctl = ctl; e.merr = merr; e.cnt = exp_cnt;
        e.lat = lat; e.memc = memc_e; e.rdc = rdc_e; e.wrc = wrc_e;
        sb.push_back(e);
        for (int i = 0; i < iw; i++) begin
            bus.imem_ready = 1'b0; bus.OpCode = op; bus.funct = fn;
            step();
        end
        bus.OpCode = op; bus.funct = fn; bus.imem_ready = 1'b1;
        step();
        // Junk on the instruction bus and a stray dmem_ready must both be ignored now.
        bus.imem_ready = 1'b0;
        bus.OpCode     = 6'($urandom);
        bus.funct      = 6'($urandom);
        bus.dmem_ready = 1'b1;
        n = 0;
        while (bus.state != 3'd3 && !bus.PC_en && n < 40) begin step(); n++; end
        if (bus.state == 3'd3) begin
            for (int i = 0; i < dw && bus.state == 3'd3; i++) begin
                bus.dmem_ready = 1'b0;
                step();
            end
            bus.dmem_ready = 1'b1;
            n = 0;
            while (!bus.PC_en && n < 40) begin step(); n++; end
        end
        bus.dmem_ready = 1'b0;
        if (!bus.PC_en) check({name, "_wb_timeout"}, 0, 1);
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},   int'(bus.state), 0);
        check({tag, "_strobes"}, int'({bus.MemRead, bus.MemWrite, bus.RegWrite, bus.PC_en, bus.mem_error}), 0);
        check({tag, "_ctl"},     int'(ctl_now()), 0);
        check({tag, "_count"},   int'(bus.instr_count), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        bus.OpCode = '0; bus.funct = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        exp_cnt = '0;
        repeat (3) step();
        check_reset_state("por");
        reset = 1'b1;
        step();

        run_instr("add",        6'b000000, 6'b100000, 0, 0,   C_ADD,  1'b0, 4,  0,  0,  0);
        run_instr("lw_wait3",   6'b100011, 6'b000000, 0, 3,   C_LW,   1'b0, 8,  4,  4,  0);
        run_instr("sw_timeout", 6'b101011, 6'b000000, 0, 100, C_SW,   1'b1, 20, 16, 0,  16);
        run_instr("jal",        6'b000011, 6'b000000, 0, 0,   C_JAL,  1'b0, 4,  0,  0,  0);
        run_instr("jr",         6'b000000, 6'b001000, 0, 0,   C_JR,   1'b0, 4,  0,  0,  0);
        run_instr("beq",        6'b000100, 6'b000000, 0, 0,   C_BEQ,  1'b0, 4,  0,  0,  0);
        run_instr("addi",       6'b001000, 6'b000000, 0, 0,   C_ADDI, 1'b0, 4,  0,  0,  0);
        run_instr("j",          6'b000010, 6'b000000, 0, 0,   C_J,    1'b0, 4,  0,  0,  0);
        run_instr("illegal",    6'b111111, 6'b000000, 0, 0,   C_ILL,  1'b0, 3,  0,  0,  0);
        run_instr("add_iwait2", 6'b000000, 6'b100000, 2, 0,   C_ADD,  1'b0, 6,  0,  0,  0);
        run_instr("sw_fast",    6'b101011, 6'b000000, 0, 0,   C_SW,   1'b0, 5,  1,  0,  1);
        run_instr("lw_fast",    6'b100011, 6'b000000, 0, 0,   C_LW,   1'b0, 5,  1,  1,  0);

        // Reset asserted for two cycles in the middle of an lw MEM phase.
        bus.OpCode = 6'b100011; bus.funct = '0; bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        n = 0;
        while (bus.state != 3'd3 && n < 10) begin step(); n++; end
        check("rstmem_reach_mem", int'(bus.state), 3);
        step();
        check("rstmem_memread", int'(bus.MemRead), 1);
        reset = 1'b0;
        step();
        step();
        check_reset_state("rstmem_held");
        reset = 1'b1;
        exp_cnt = '0;
        step();
        check_reset_state("rstmem_released");

        // Fifteen retires bring the 4-bit counter to all-ones; an illegal opcode wraps it.
        for (int i = 0; i < 15; i++) begin
            case (i % 4)
                0:       run_instr("wrap_add",  6'b000000, 6'b100000, 0, 0, C_ADD,  1'b0, 4, 0, 0, 0);
                1:       run_instr("wrap_addi", 6'b001000, 6'b000000, 0, 0, C_ADDI, 1'b0, 4, 0, 0, 0);
                2:       run_instr("wrap_beq",  6'b000100, 6'b000000, 0, 0, C_BEQ,  1'b0, 4, 0, 0, 0);
                default: run_instr("wrap_lw",   6'b100011, 6'b000000, 0, 1, C_LW,   1'b0, 6, 2, 2, 0);
            endcase
        end
        run_instr("wrap_illegal", 6'b111111, 6'b000000, 0, 0, C_ILL, 1'b0, 3, 0, 0, 0);

        step();
        step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
